// File: rtl/mult_shift_sched.sv
// Round-robin sequencer sharing one N-step shift-add multiplier core between two requesters.
// Optional `MULT_ZERO_BYPASS_EN: zero operands skip the core and return 0 in one cycle.
module mult_shift_sched #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_product,
  output logic           busy,
  output logic [N-1:0]   core_multiplicand,
  output logic [N-1:0]   core_multiplier,
  output logic           core_load,
  output logic           core_en,
  input  logic [2*N-1:0] core_product
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic            id_q;
  logic            last_grant_q;
  logic [CntW-1:0] cnt_q;

  logic            idle;
  logic            gnt0, gnt1;
  logic            accept;
  logic            sel_id;
  logic [N-1:0]    sel_a, sel_b;
  logic            sel_zero;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    idle     = (state_q == StIdle) && !rst;
    gnt0     = req0_valid && (!req1_valid || last_grant_q);
    gnt1     = req1_valid && (!req0_valid || !last_grant_q);
    accept   = idle && (gnt0 || gnt1);
    sel_id   = gnt1;
    sel_a    = gnt1 ? req1_a : req0_a;
    sel_b    = gnt1 ? req1_b : req0_b;
    sel_zero = (sel_a == '0) || (sel_b == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef MULT_ZERO_BYPASS_EN
          state_d = sel_zero ? StResp : StLoad;
`else
          state_d = StLoad;
`endif
        end
      end
      StLoad: state_d = StRun;
      StRun:  if (cnt_q == CntW'(N - 1)) state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef MULT_ZERO_BYPASS_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= sel_zero;
    end
  end
`else
  logic unused_sel_zero;
  assign unused_sel_zero = sel_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        a_q          <= sel_a;
        b_q          <= sel_b;
        id_q         <= sel_id;
        last_grant_q <= sel_id;
      end
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    req0_ready        = idle && gnt0;
    req1_ready        = idle && gnt1;
    busy              = !rst && (state_q != StIdle);
    core_load         = rst || (state_q == StLoad);
    core_en           = !rst && (state_q == StRun);
    core_multiplicand = a_q;
    core_multiplier   = b_q;
    rsp_valid         = !rst && (state_q == StResp);
    rsp_id            = id_q;
`ifdef MULT_ZERO_BYPASS_EN
    rsp_product       = zero_q ? '0 : core_product;
`else
    rsp_product       = core_product;
`endif
  end

endmodule
